sram_arbiter: RTL and testbench

Two-master to one-slave arbiter for the sram_like bus. It shares a single memory port between the instruction-fetch side and the mem stage's data side, and sits between the CPU core and the AXI bridge. It keeps a tag FIFO of the owners of outstanding transactions, so each `data_ok`/`rdata` response is returned to the requester that issued the address phase.

---
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Two-master (inst/data) to one-slave sram_like arbiter with an owner-tag FIFO for in-order response routing.
// Optional SRAM_ARB_RR_EN: round-robin unlocked grant instead of fixed data-over-inst priority.
module sram_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    input  logic [31:0] m_rdata,

    output logic        busy
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    // Owner encoding throughout: 0 = inst, 1 = data.
    logic [DEPTH-1:0] r_tag;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             r_lock_valid;
    logic             r_lock_owner;
    logic             r_hold_grant;
`ifdef SRAM_ARB_RR_EN
    logic             r_last_owner;
`endif

    logic w_full;
    logic w_free_grant;
    logic w_grant;
    logic w_greq;
    logic w_push;
    logic w_pop;
    logic w_pop_owner;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full = (r_count == CW'(DEPTH));

    always_comb begin
        w_free_grant = r_hold_grant;
`ifdef SRAM_ARB_RR_EN
        if (inst_req && data_req)
            w_free_grant = ~r_last_owner;
        else if (data_req)
            w_free_grant = 1'b1;
        else if (inst_req)
            w_free_grant = 1'b0;
`else
        if (data_req)
            w_free_grant = 1'b1;
        else if (inst_req)
            w_free_grant = 1'b0;
`endif
    end

    // A request left waiting on the slave keeps the bus until it is accepted.
    assign w_grant = r_lock_valid ? r_lock_owner : w_free_grant;
    assign w_greq  = w_grant ? data_req : inst_req;

    assign m_req   = w_greq & ~w_full & ~reset;
    assign m_wr    = w_grant ? data_wr    : inst_wr;
    assign m_size  = w_grant ? data_size  : inst_size;
    assign m_addr  = w_grant ? data_addr  : inst_addr;
    assign m_wdata = w_grant ? data_wdata : inst_wdata;

    assign w_push = m_req & m_addr_ok;
    assign w_pop  = m_data_ok & (r_count != '0) & ~reset;

    assign inst_addr_ok = w_push & ~w_grant;
    assign data_addr_ok = w_push &  w_grant;

    assign w_pop_owner  = r_tag[r_rd_ptr];
    assign inst_data_ok = w_pop & ~w_pop_owner;
    assign data_data_ok = w_pop &  w_pop_owner;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    assign busy = (r_count != '0) & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag        <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_count      <= '0;
            r_lock_valid <= 1'b0;
            r_lock_owner <= 1'b0;
            r_hold_grant <= 1'b0;
        end else begin
            if (w_push) begin
                r_tag[r_wr_ptr] <= w_grant;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (m_req && !m_addr_ok) begin
                r_lock_valid <= 1'b1;
                r_lock_owner <= w_grant;
            end else if (w_push) begin
                r_lock_valid <= 1'b0;
            end

            r_hold_grant <= w_grant;
        end
    end

`ifdef SRAM_ARB_RR_EN
    // Reset to data so that inst wins the first tie.
    always_ff @(posedge clk) begin
        if (reset)
            r_last_owner <= 1'b1;
        else if (w_push)
            r_last_owner <= w_grant;
    end
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter (default build, DEPTH=2): directed scenarios plus a randomized run against a queue-based model.
module tb_sram_arbiter;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    sram_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        cyc(); cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        cyc();
        inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
        #1;
        n_checks++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL reset_mreq got=%0b exp=0", m_req); end
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_addr_ok got=%b exp=00", {inst_addr_ok, data_addr_ok}); end
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin n_fail++; $display("FAIL reset_data_ok got=%b exp=00", {inst_data_ok, data_data_ok}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        cyc();
        reset = 0;
        idle_inputs();
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        inst_req = 1; inst_addr = 32'h100; data_req = 1; data_addr = 32'h200; m_addr_ok = 1;
        #1;
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin n_fail++; $display("FAIL simul_first_grant got=%b exp=01", {inst_addr_ok, data_addr_ok}); end
        n_checks++; if (m_addr !== 32'h200) begin n_fail++; $display("FAIL simul_first_addr got=%h exp=00000200", m_addr); end
        cyc();
        data_req = 0;
        #1;
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL simul_second_grant got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
        n_checks++; if (m_addr !== 32'h100) begin n_fail++; $display("FAIL simul_second_addr got=%h exp=00000100", m_addr); end
        cyc();
        inst_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'h11;
        #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL simul_resp1 got=%b exp=01", {inst_data_ok, data_data_ok}); end
        cyc();
        m_rdata = 32'h22;
        #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin n_fail++; $display("FAIL simul_resp2 got=%b exp=10", {inst_data_ok, data_data_ok}); end
        cyc();
        m_data_ok = 0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL simul_drained_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_lock_hold();
        do_reset();
        data_req = 1; data_addr = 32'h1000; m_addr_ok = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin inst_req = 1; inst_addr = 32'h2000; end
            if (c == 3) m_addr_ok = 1;
            #1;
            n_checks++; if (m_addr !== 32'h1000) begin n_fail++; $display("FAIL lock_addr c=%0d got=%h exp=00001000", c, m_addr); end
            n_checks++; if (inst_addr_ok !== 1'b0 || data_addr_ok !== (c == 3)) begin n_fail++; $display("FAIL lock_addr_ok c=%0d got=%b", c, {inst_addr_ok, data_addr_ok}); end
            cyc();
        end
        data_req = 0;
        #1;
        n_checks++; if (m_addr !== 32'h2000 || inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL lock_inst_after got=%h/%0b exp=00002000/1", m_addr, inst_addr_ok); end
        // Lower-priority master locked first: the arriving data request must wait.
        do_reset();
        inst_req = 1; inst_addr = 32'h3000; m_addr_ok = 0;
        cyc();
        data_req = 1; data_addr = 32'h4000;
        #1;
        n_checks++; if (m_addr !== 32'h3000 || data_addr_ok !== 1'b0) begin n_fail++; $display("FAIL lock_inst_held got=%h/%0b exp=00003000/0", m_addr, data_addr_ok); end
        m_addr_ok = 1;
        #1;
        n_checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin n_fail++; $display("FAIL lock_inst_accept got=%b exp=10", {inst_addr_ok, data_addr_ok}); end
        cyc();
        inst_req = 0;
        #1;
        n_checks++; if (m_addr !== 32'h4000 || data_addr_ok !== 1'b1) begin n_fail++; $display("FAIL lock_data_after got=%h/%0b exp=00004000/1", m_addr, data_addr_ok); end
    endtask

    task automatic test_full_stall();
        do_reset();
        inst_req = 1; inst_addr = 32'h40; m_addr_ok = 1;
        #1;
        n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_acc1 got=%0b exp=1", inst_addr_ok); end
        cyc();
        n_checks++; if (inst_addr_ok !== 1'b1) begin n_fail++; $display("FAIL full_acc2 got=%0b exp=1", inst_addr_ok); end
        cyc();
        n_checks++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin n_fail++; $display("FAIL full_stall got=%b exp=00", {m_req, inst_addr_ok}); end
        m_data_ok = 1; m_rdata = 32'h5;
        #1;
        n_checks++; if (inst_data_ok !== 1'b1 || m_req !== 1'b0) begin n_fail++; $display("FAIL full_pop_cycle got=%b exp=10", {inst_data_ok, m_req}); end
        cyc();
        m_data_ok = 0;
        #1;
        n_checks++; if (m_req !== 1'b1) begin n_fail++; $display("FAIL full_reassert got=%0b exp=1", m_req); end
    endtask

    task automatic test_routing();
        do_reset();
        inst_req = 1; inst_addr = 32'h10; m_addr_ok = 1;
        cyc();
        inst_req = 0; data_req = 1; data_addr = 32'h20;
        cyc();
        data_req = 0; m_addr_ok = 0; m_data_ok = 1; m_rdata = 32'hAAAA0001;
        #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b10 || inst_rdata !== 32'hAAAA0001) begin n_fail++; $display("FAIL route_inst got=%b/%h exp=10/aaaa0001", {inst_data_ok, data_data_ok}, inst_rdata); end
        cyc();
        m_rdata = 32'hBBBB0002;
        #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01 || data_rdata !== 32'hBBBB0002) begin n_fail++; $display("FAIL route_data got=%b/%h exp=01/bbbb0002", {inst_data_ok, data_data_ok}, data_rdata); end
        cyc();
        m_data_ok = 0;
    endtask

    task automatic test_push_pop();
        do_reset();
        inst_req = 1; inst_addr = 32'h50; m_addr_ok = 1;
        cyc();
        inst_req = 0; data_req = 1; data_addr = 32'h60; m_data_ok = 1; m_rdata = 32'h77;
        #1;
        n_checks++; if ({inst_data_ok, data_addr_ok} !== 2'b11) begin n_fail++; $display("FAIL pushpop_same got=%b exp=11", {inst_data_ok, data_addr_ok}); end
        cyc();
        data_req = 0; m_addr_ok = 0; m_data_ok = 0;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pushpop_busy got=%0b exp=1", busy); end
        m_data_ok = 1;
        #1;
        n_checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin n_fail++; $display("FAIL pushpop_order got=%b exp=01", {inst_data_ok, data_data_ok}); end
        cyc();
        m_data_ok = 0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pushpop_empty got=%0b exp=0", busy); end
    endtask

    task automatic test_reset_spurious();
        do_reset();
        inst_req = 1; m_addr_ok = 1;
        cyc(); cyc();
        idle_inputs();
        #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL spur_busy_before got=%0b exp=1", busy); end
        reset = 1;
        cyc();
        reset = 0; m_data_ok = 1; m_rdata = 32'h99;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++; if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin n_fail++; $display("FAIL spur_resp c=%0d got=%b exp=000", c, {inst_data_ok, data_data_ok, busy}); end
            cyc();
        end
        m_data_ok = 0;
    endtask

    // Randomized masters that hold each request until accepted, against a queue of owners.
    task automatic test_random();
        bit ip, dp;
        bit lk_v, lk_o, lastg, g, greq, full, exp_mreq, exp_pop, exp_own, push;
        logic [31:0] ia, da, iw, dw;
        bit iwr, dwr;
        bit owners[$];
        do_reset();
        ip = 0; dp = 0; lk_v = 0; lk_o = 0; lastg = 0;
        ia = 0; da = 0; iw = 0; dw = 0; iwr = 0; dwr = 0;
        for (int c = 0; c < 600; c++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin ip = 1; ia = $urandom; iw = $urandom; iwr = 1'($urandom_range(0, 1)); end
            if (!dp && $urandom_range(0, 2) == 0) begin dp = 1; da = $urandom; dw = $urandom; dwr = 1'($urandom_range(0, 1)); end
            inst_req = ip; inst_addr = ia; inst_wdata = iw; inst_wr = iwr;
            data_req = dp; data_addr = da; data_wdata = dw; data_wr = dwr;
            m_addr_ok = 1'($urandom_range(0, 1));
            m_data_ok = ($urandom_range(0, 2) == 0);
            m_rdata = $urandom;
            #1;
            full = (owners.size() >= DEPTH);
            g = lk_v ? lk_o : (dp ? 1'b1 : (ip ? 1'b0 : lastg));
            greq = g ? dp : ip;
            exp_mreq = greq && !full;
            push = exp_mreq && m_addr_ok;
            exp_pop = m_data_ok && owners.size() > 0;
            exp_own = (owners.size() > 0) ? owners[0] : 1'b0;
            n_checks++; if (m_req !== exp_mreq) begin n_fail++; $display("FAIL rnd_mreq c=%0d got=%0b exp=%0b", c, m_req, exp_mreq); end
            if (exp_mreq) begin
                n_checks++; if (m_addr !== (g ? da : ia) || m_wdata !== (g ? dw : iw) || m_wr !== (g ? dwr : iwr)) begin
                    n_fail++; $display("FAIL rnd_mux c=%0d got=%h exp=%h", c, m_addr, g ? da : ia); end
            end
            n_checks++; if (inst_addr_ok !== (push && !g) || data_addr_ok !== (push && g)) begin
                n_fail++; $display("FAIL rnd_addr_ok c=%0d got=%b exp=%b", c, {inst_addr_ok, data_addr_ok}, {push && !g, push && g}); end
            n_checks++; if (inst_data_ok !== (exp_pop && !exp_own) || data_data_ok !== (exp_pop && exp_own)) begin
                n_fail++; $display("FAIL rnd_data_ok c=%0d got=%b exp=%b", c, {inst_data_ok, data_data_ok}, {exp_pop && !exp_own, exp_pop && exp_own}); end
            n_checks++; if (inst_rdata !== m_rdata || data_rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c=%0d got=%h exp=%h", c, inst_rdata, m_rdata); end
            n_checks++; if (busy !== (owners.size() != 0)) begin n_fail++; $display("FAIL rnd_busy c=%0d got=%0b exp=%0b", c, busy, owners.size() != 0); end
            if (exp_pop) void'(owners.pop_front());
            if (push) begin
                owners.push_back(g);
                if (g) dp = 0; else ip = 0;
            end
            if (exp_mreq && !m_addr_ok) begin lk_v = 1; lk_o = g; end
            else if (push) lk_v = 0;
            lastg = g;
            cyc();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_simultaneous();
        test_lock_hold();
        test_full_stall();
        test_routing();
        test_push_pop();
        test_reset_spurious();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
